// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared FSM state encoding, read-response codes and default widths
package axi_pkg;

    localparam int ADDR_WIDTH_DEF      = 32;
    localparam int DATA_WIDTH_DEF      = 32;
    localparam int BURST_LEN_WIDTH_DEF = 8;

    localparam logic [1:0] RRESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb2_grant.sv
// rtl/arb2_grant.sv - two-way one-hot grant; on a tie the port named by ptr wins
module arb2_grant (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two requesters sharing one read-burst master, beats routed back to the owner
// AXI_RD_ARB_RR_EN: round-robin tie-break; otherwise port 0 has fixed priority
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int BURST_LEN_WIDTH = BURST_LEN_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    input  logic [ADDR_WIDTH-1:0]      req0_addr,
    input  logic [BURST_LEN_WIDTH-1:0] req0_len,
    output logic                       req0_ready,
    output logic                       req0_rvalid,
    output logic [DATA_WIDTH-1:0]      req0_rdata,
    output logic                       req0_done,
    output logic                       req0_err,
    input  logic                       req1_valid,
    input  logic [ADDR_WIDTH-1:0]      req1_addr,
    input  logic [BURST_LEN_WIDTH-1:0] req1_len,
    output logic                       req1_ready,
    output logic                       req1_rvalid,
    output logic [DATA_WIDTH-1:0]      req1_rdata,
    output logic                       req1_done,
    output logic                       req1_err,
    output logic                       m_start,
    output logic [ADDR_WIDTH-1:0]      m_addr,
    output logic [BURST_LEN_WIDTH-1:0] m_len,
    input  logic                       m_rvalid,
    input  logic [DATA_WIDTH-1:0]      m_rdata,
    input  logic [1:0]                 m_rresp,
    input  logic                       m_done
);

    arb_state_t state;
    arb_state_t state_next;
    logic       grant_id;
    logic       err_acc;
    logic       ptr;
    logic [1:0] grant;
    logic       in_busy;
    logic       own0;
    logic       own1;
    logic       beat_err;
    logic       arb_take;

    assign arb_take = (state == IDLE) && (req0_valid || req1_valid);

    arb2_grant u_grant (
        .req   ({req1_valid, req0_valid}),
        .ptr   (ptr),
        .grant (grant)
    );

`ifdef AXI_RD_ARB_RR_EN
    // Pointer moves to the port that just lost, so it wins the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (arb_take) begin
            ptr <= ~grant[1];
        end
    end
`else
    assign ptr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= 1'b0;
            m_addr   <= '0;
            m_len    <= '0;
            err_acc  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (arb_take) begin
                        grant_id <= grant[1];
                        m_addr   <= grant[1] ? req1_addr : req0_addr;
                        m_len    <= grant[1] ? req1_len  : req0_len;
                    end
                end
                ISSUE:   err_acc <= 1'b0;
                BUSY:    if (beat_err) err_acc <= 1'b1;
                default: err_acc <= err_acc;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        m_start    = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (arb_take) state_next = ISSUE;
            end
            ISSUE: begin
                state_next = BUSY;
                m_start    = 1'b1;
                req0_ready = ~grant_id;
                req1_ready = grant_id;
            end
            BUSY: begin
                if (m_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Return path is purely combinational so beats reach the owner with no added latency.
    assign in_busy  = (state == BUSY);
    assign own0     = in_busy && !grant_id;
    assign own1     = in_busy && grant_id;
    assign beat_err = in_busy && m_rvalid && (m_rresp != RRESP_OKAY);

    assign req0_rvalid = own0 && m_rvalid;
    assign req1_rvalid = own1 && m_rvalid;
    assign req0_rdata  = own0 ? m_rdata : '0;
    assign req1_rdata  = own1 ? m_rdata : '0;
    assign req0_done   = own0 && m_done;
    assign req1_done   = own1 && m_done;
    assign req0_err    = req0_done && (err_acc || beat_err);
    assign req1_err    = req1_done && (err_acc || beat_err);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - randomized bench for axi_rd_arbiter with a transaction-level reference model
`timescale 1ns/1ps
module tb_axi_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rv [2];
    logic [AW-1:0] ra [2];
    logic [LW-1:0] rl [2];
    logic          req0_ready, req1_ready, req0_rvalid, req1_rvalid;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic          req0_done, req1_done, req0_err, req1_err;
    logic          m_start;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_len;
    logic          m_rvalid = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]    m_rresp = 2'b00;
    logic          m_done = 1'b0;

    axi_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(rv[0]), .req0_addr(ra[0]), .req0_len(rl[0]), .req0_ready(req0_ready),
        .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata), .req0_done(req0_done), .req0_err(req0_err),
        .req1_valid(rv[1]), .req1_addr(ra[1]), .req1_len(rl[1]), .req1_ready(req1_ready),
        .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata), .req1_done(req1_done), .req1_err(req1_err),
        .m_start(m_start), .m_addr(m_addr), .m_len(m_len),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_done(m_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: who owns the master, when its start pulse is due, error history.
    int            g_port = -1;
    int            g_start = 0;
    bit            g_err = 1'b0;
    int            arb_ok = 0;
    int            ptr = 0;
    logic [AW-1:0] e_addr = '0;
    logic [LW-1:0] e_len = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        logic          x_start;
        logic [1:0]    x_rdy, x_rv, x_done, x_err;
        logic [DW-1:0] x_d0, x_d1;
        bit            in_burst;
        int            w;
        x_start = 1'b0; x_rdy = 2'b00; x_rv = 2'b00; x_done = 2'b00; x_err = 2'b00;
        x_d0 = '0; x_d1 = '0; w = 0;
        in_burst = !rst && g_port >= 0 && cyc > g_start;
        if (!rst && g_port >= 0 && cyc == g_start) begin
            x_start = 1'b1;
            x_rdy[g_port] = 1'b1;
        end
        if (in_burst) begin
            x_rv[g_port]   = m_rvalid;
            x_done[g_port] = m_done;
            x_err[g_port]  = m_done && (g_err || (m_rvalid && m_rresp != 2'b00));
            if (g_port == 0) x_d0 = m_rdata;
            else             x_d1 = m_rdata;
        end
        chk("m_start", 64'(m_start), 64'(x_start));
        chk("ready", 64'({req1_ready, req0_ready}), 64'(x_rdy));
        chk("rvalid", 64'({req1_rvalid, req0_rvalid}), 64'(x_rv));
        chk("done", 64'({req1_done, req0_done}), 64'(x_done));
        chk("err", 64'({req1_err, req0_err}), 64'(x_err));
        chk("rdata0", 64'(req0_rdata), 64'(x_d0));
        chk("rdata1", 64'(req1_rdata), 64'(x_d1));
        chk("m_addr", 64'(m_addr), rst ? 64'd0 : 64'(e_addr));
        chk("m_len", 64'(m_len), rst ? 64'd0 : 64'(e_len));
        if (rst) begin
            g_port = -1; g_err = 1'b0; ptr = 0; e_addr = '0; e_len = '0; arb_ok = 0;
        end else if (in_burst) begin
            if (m_rvalid && m_rresp != 2'b00) g_err = 1'b1;
            if (m_done) begin
                g_port = -1;
                arb_ok = cyc + 1;
            end
        end else if (g_port >= 0) begin
            g_err = 1'b0;
        end else if (cyc >= arb_ok && (rv[0] || rv[1])) begin
            w = (rv[0] && rv[1]) ? ptr : (rv[1] ? 1 : 0);
            g_port = w; g_start = cyc + 1; e_addr = ra[w]; e_len = rl[w];
`ifdef AXI_RD_ARB_RR_EN
            ptr = 1 - w;
`endif
        end
        cyc++;
    end

    // Stimulus knobs and observation counters.
    int            cfg_beats = 0, err_beat = -1, err_pct = 0, gap_pct = 0, stray_pct = 0;
    int            dwl_mode = 0, req_pct = 100;
    int            want [2];
    int            req_cyc [2];
    bit            fix_addr = 1'b0;
    bit            mb = 1'b0, dwl = 1'b0;
    int            left = 0, bidx = 0;
    int            cnt_rv [2];
    int            cnt_done [2];
    logic          last_err [2];
    int            starts [$];
    int            grants [$];
    logic [AW-1:0] st_addr = '0;
    logic [LW-1:0] st_len = '0;

    task automatic cycle();
        logic [1:0] rdy;
        logic       st;
        @(posedge clk); #1;
        rdy = {req1_ready, req0_ready};
        st  = m_start;
        for (int p = 0; p < 2; p++) begin
            if (rv[p] && rdy[p]) begin
                rv[p] = 1'b0;
                grants.push_back(p);
            end
            if (!rv[p] && want[p] > 0 && !rst && $urandom_range(0, 99) < req_pct) begin
                rv[p] = 1'b1;
                want[p]--;
                ra[p] = fix_addr ? 32'h1000 : $urandom;
                rl[p] = fix_addr ? 8'd7 : 8'($urandom);
                req_cyc[p] = cyc;
            end
        end
        m_rvalid = 1'b0; m_done = 1'b0; m_rresp = 2'b00; m_rdata = $urandom;
        if (st) begin
            mb   = 1'b1;
            left = cfg_beats > 0 ? cfg_beats : $urandom_range(1, 6);
            bidx = 0;
            dwl  = dwl_mode < 0 ? 1'($urandom_range(0, 1)) : 1'(dwl_mode);
        end else if (mb) begin
            if (left == 0) begin
                m_done = 1'b1;
                mb = 1'b0;
            end else if ($urandom_range(0, 99) >= gap_pct) begin
                m_rvalid = 1'b1;
                if (bidx == err_beat || $urandom_range(0, 99) < err_pct) m_rresp = 2'($urandom_range(1, 3));
                bidx++;
                left--;
                if (left == 0 && dwl) begin
                    m_done = 1'b1;
                    mb = 1'b0;
                end
            end
        end else if ($urandom_range(0, 99) < stray_pct) begin
            m_rvalid = 1'($urandom_range(0, 1));
            m_done   = 1'($urandom_range(0, 1));
            m_rresp  = 2'($urandom);
        end
        #1;
        if (m_start) begin
            starts.push_back(cyc);
            st_addr = m_addr;
            st_len  = m_len;
        end
        cnt_rv[0] += int'(req0_rvalid);
        cnt_rv[1] += int'(req1_rvalid);
        if (req0_done) begin cnt_done[0]++; last_err[0] = req0_err; end
        if (req1_done) begin cnt_done[1]++; last_err[1] = req1_err; end
    endtask

    task automatic run_until_done(input int p, input int target, input int max_cyc, input string name);
        int n;
        n = 0;
        while (cnt_done[p] < target && n < max_cyc) begin
            cycle();
            n++;
        end
        chk(name, 64'(cnt_done[p] >= target), 64'd1);
    endtask

    initial begin : main
        int base, d0, n0, s_rv, s_done, s_start, n;
        int exp_order [4];
        for (int p = 0; p < 2; p++) begin
            rv[p] = 1'b0; ra[p] = '0; rl[p] = '0; want[p] = 0; req_cyc[p] = 0;
            cnt_rv[p] = 0; cnt_done[p] = 0; last_err[p] = 1'b0;
        end
        repeat (3) cycle();
        chk("reset m_addr", 64'(m_addr), 64'd0);
        chk("reset m_start", 64'(m_start), 64'd0);

        // Single 8-beat burst from port 0.
        rst = 1'b0;
        cfg_beats = 8; fix_addr = 1'b1; want[0] = 1;
        run_until_done(0, 1, 60, "basic burst done");
        chk("basic start latency", 64'(starts[$] - req_cyc[0]), 64'd1);
        chk("basic m_addr", 64'(st_addr), 64'h1000);
        chk("basic m_len", 64'(st_len), 64'd7);
        chk("basic beats port0", 64'(cnt_rv[0]), 64'd8);
        chk("basic beats port1", 64'(cnt_rv[1]), 64'd0);
        chk("basic err", 64'(last_err[0]), 64'd0);

        // Error on one beat, then a clean burst.
        fix_addr = 1'b0; cfg_beats = 6; err_beat = 3; want[1] = 1;
        run_until_done(1, 1, 60, "err burst done");
        chk("err burst flag", 64'(last_err[1]), 64'd1);
        err_beat = -1; want[1] = 1;
        run_until_done(1, 2, 60, "clean burst done");
        chk("clean burst flag", 64'(last_err[1]), 64'd0);

        // Stray master pulses while idle.
        s_rv = cnt_rv[0] + cnt_rv[1]; s_done = cnt_done[0] + cnt_done[1]; s_start = starts.size();
        stray_pct = 100;
        repeat (12) cycle();
        chk("idle stray rvalid", 64'(cnt_rv[0] + cnt_rv[1] - s_rv), 64'd0);
        chk("idle stray done", 64'(cnt_done[0] + cnt_done[1] - s_done), 64'd0);
        chk("idle stray start", 64'(starts.size() - s_start), 64'd0);

        // Last beat together with done; back-to-back requests.
        stray_pct = 0; cfg_beats = 1; dwl_mode = 1;
        n0 = starts.size(); d0 = cnt_done[0] + cnt_done[1]; s_rv = cnt_rv[0] + cnt_rv[1];
        want[0] = 2; want[1] = 2; n = 0;
        while (cnt_done[0] + cnt_done[1] < d0 + 4 && n < 80) begin cycle(); n++; end
        chk("merged done count", 64'(cnt_done[0] + cnt_done[1] - d0), 64'd4);
        chk("merged beat count", 64'(cnt_rv[0] + cnt_rv[1] - s_rv), 64'd4);
        chk("start gap", 64'(starts[n0 + 1] - starts[n0]), 64'd3);

        // Reset in the middle of a burst.
        cfg_beats = 8; dwl_mode = 0; want[0] = 1; base = cnt_rv[0]; n = 0;
        while (cnt_rv[0] - base < 4 && n < 40) begin cycle(); n++; end
        chk("midburst beats reached", 64'(cnt_rv[0] - base >= 4), 64'd1);
        rst = 1'b1; m_done = 1'b1; mb = 1'b0;
        #1;
        chk("reset rvalid", 64'({req1_rvalid, req0_rvalid}), 64'd0);
        chk("reset done", 64'({req1_done, req0_done}), 64'd0);
        chk("reset m_addr mid", 64'(m_addr), 64'd0);
        d0 = cnt_done[0]; stray_pct = 100;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (4) cycle();
        chk("no done after abort", 64'(cnt_done[0]), 64'(d0));
        stray_pct = 0; want[1] = 1;
        run_until_done(1, cnt_done[1] + 1, 60, "post reset burst done");
        chk("post reset grant", 64'(grants[$]), 64'd1);

        // Both ports requesting from reset: arbitration order.
        rst = 1'b1; mb = 1'b0;
        cycle();
        grants.delete();
        cfg_beats = 0; dwl_mode = -1; want[0] = 4; want[1] = 4;
        rst = 1'b0; n = 0;
        while (grants.size() < 4 && n < 200) begin cycle(); n++; end
`ifdef AXI_RD_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) chk("grant order", 64'(grants[i]), 64'(exp_order[i]));

        // Randomized traffic with rare resets.
        stray_pct = 10; gap_pct = 30; err_pct = 15; req_pct = 40;
        for (int i = 0; i < 2000; i++) begin
            for (int p = 0; p < 2; p++) if (want[p] == 0) want[p] = $urandom_range(0, 3);
            cycle();
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1; mb = 1'b0; rv[0] = 1'b0; rv[1] = 1'b0;
                cycle();
                cycle();
                rst = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
